// File: rtl/mem_lsu.sv
// Memory stage load/store unit: decodes loads/stores from the EX/MEM register,
// runs a req/gnt/rvalid data-bus handshake and produces the writeback/forward value.
module mem_lsu #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned PC_WIDTH      = 32,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned REG_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_WIDTH-1:0]      ex_mem_pc_i,
    input  logic [INSTR_WIDTH-1:0]   ex_mem_instr_i,
    input  logic [XLEN-1:0]          ex_mem_rs2_rdata_i,
    input  logic [XLEN-1:0]          ex_mem_alu_res_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_mem_rd_idx_i,
    input  logic                     ex_mem_rd_en_i,
    input  logic [XLEN-1:0]          ex_mem_rd_wdata_i,
    output logic                     dbus_req_o,
    input  logic                     dbus_gnt_i,
    output logic                     dbus_we_o,
    output logic [XLEN-1:0]          dbus_addr_o,
    output logic [3:0]               dbus_be_o,
    output logic [XLEN-1:0]          dbus_wdata_o,
    input  logic                     dbus_rvalid_i,
    input  logic [XLEN-1:0]          dbus_rdata_i,
    output logic                     mem_stall_o,
    output logic [PC_WIDTH-1:0]      mem_pc_o,
    output logic [INSTR_WIDTH-1:0]   mem_instr_o,
    output logic [REG_IDX_WIDTH-1:0] mem_rd_idx_o,
    output logic                     mem_rd_en_o,
    output logic [XLEN-1:0]          mem_rd_wdata_o,
    output logic                     mem_misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      size;
    logic [XLEN-1:0] addr;
    logic            is_load, is_store, is_mem, misaligned, mem_ok;
    logic            idle_mem, stall;
    logic [XLEN-1:0] shifted, load_ext;

    assign opcode = ex_mem_instr_i[6:0];
    assign funct3 = ex_mem_instr_i[14:12];
    assign size   = funct3[1:0];
    assign addr   = ex_mem_alu_res_i;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        if (opcode == 7'b0000011)
            is_load = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        if (opcode == 7'b0100011)
            is_store = funct3 inside {3'b000, 3'b001, 3'b010};
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
    assign mem_ok     = is_mem & ~misaligned;

    // Bus request fields depend only on the held instruction, so they stay stable across REQ.
    assign dbus_addr_o = {addr[XLEN-1:2], 2'b00};
    assign dbus_we_o   = is_store;

    always_comb begin
        case (size)
            2'b00:   begin
                dbus_be_o    = 4'b0001 << addr[1:0];
                dbus_wdata_o = {(XLEN/8){ex_mem_rs2_rdata_i[7:0]}};
            end
            2'b01:   begin
                dbus_be_o    = 4'b0011 << {addr[1], 1'b0};
                dbus_wdata_o = {(XLEN/16){ex_mem_rs2_rdata_i[15:0]}};
            end
            default: begin
                dbus_be_o    = 4'b1111;
                dbus_wdata_o = ex_mem_rs2_rdata_i;
            end
        endcase
    end

    assign shifted = dbus_rdata_i >> {addr[1:0], 3'b000};

    always_comb begin
        case (funct3)
            3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE, REQ: begin
                if (mem_ok || state_q == REQ) begin
                    if (dbus_gnt_i) state_d = is_load ? WAIT : DONE;
                    else            state_d = REQ;
                end
            end
            WAIT: begin
                if (dbus_rvalid_i) begin
                    load_data_d = load_ext;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
        end
    end

    assign idle_mem = (state_q == IDLE) && mem_ok;
    assign stall    = ~rst & (idle_mem || state_q == REQ || state_q == WAIT);

    assign dbus_req_o     = ~rst & (idle_mem || state_q == REQ);
    assign mem_stall_o    = stall;
    assign mem_misalign_o = ~rst & is_mem & misaligned;
    assign mem_rd_en_o    = ~rst & ex_mem_rd_en_i & ~stall & ~(is_mem & misaligned);
    assign mem_rd_wdata_o = (state_q == DONE && is_load) ? load_data_q : ex_mem_rd_wdata_i;
    assign mem_pc_o       = ex_mem_pc_i;
    assign mem_instr_o    = ex_mem_instr_i;
    assign mem_rd_idx_o   = ex_mem_rd_idx_i;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: driver pushes expected writeback results, a monitor
// pops them whenever the stage is not stalled, and a bus responder models memory.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ex_mem_pc_i = '0, ex_mem_instr_i = '0, ex_mem_rs2_rdata_i = '0;
    logic [31:0] ex_mem_alu_res_i = '0, ex_mem_rd_wdata_i = '0;
    logic [4:0]  ex_mem_rd_idx_i = '0;
    logic        ex_mem_rd_en_i = 1'b0;
    logic        dbus_req_o, dbus_we_o;
    logic        dbus_gnt_i = 1'b0, dbus_rvalid_i = 1'b0;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [31:0] dbus_rdata_i = '0;
    logic [3:0]  dbus_be_o;
    logic        mem_stall_o, mem_rd_en_o, mem_misalign_o;
    logic [31:0] mem_pc_o, mem_instr_o, mem_rd_wdata_o;
    logic [4:0]  mem_rd_idx_o;

    always #5 clk = ~clk;

    mem_lsu #(.XLEN(32), .PC_WIDTH(32), .INSTR_WIDTH(32), .REG_IDX_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_pc_i(ex_mem_pc_i), .ex_mem_instr_i(ex_mem_instr_i),
        .ex_mem_rs2_rdata_i(ex_mem_rs2_rdata_i), .ex_mem_alu_res_i(ex_mem_alu_res_i),
        .ex_mem_rd_idx_i(ex_mem_rd_idx_i), .ex_mem_rd_en_i(ex_mem_rd_en_i),
        .ex_mem_rd_wdata_i(ex_mem_rd_wdata_i),
        .dbus_req_o(dbus_req_o), .dbus_gnt_i(dbus_gnt_i), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
        .mem_stall_o(mem_stall_o), .mem_pc_o(mem_pc_o), .mem_instr_o(mem_instr_o),
        .mem_rd_idx_o(mem_rd_idx_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_rd_wdata_o(mem_rd_wdata_o), .mem_misalign_o(mem_misalign_o)
    );

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_en;
        logic        mis;
        logic [4:0]  idx;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mem_b[0:63];
    int          n_cmp = 0, n_err = 0;
    bit          sb_en = 1'b0;
    bit          exp_bus = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_be = '0;
    logic        exp_we = 1'b0;
    int          gd_cnt = 0, rv_delay = 0, rv_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int b;
        b = int'(a & 32'h3C);
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    // Bus responder: grants after gd_cnt request cycles, returns read data rv_delay cycles later.
    always @(negedge clk) begin
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = $urandom;
        if (pend) begin
            if (rv_cnt == 0) begin
                dbus_rvalid_i = 1'b1;
                dbus_rdata_i  = pend_data;
                pend          = 1'b0;
            end else begin
                rv_cnt--;
            end
        end
        if (!rst && dbus_req_o) begin
            check("bus_expected", {31'b0, exp_bus}, 32'd1);
            check("bus_addr", dbus_addr_o, exp_addr);
            check("bus_be", {28'b0, dbus_be_o}, {28'b0, exp_be});
            check("bus_we", {31'b0, dbus_we_o}, {31'b0, exp_we});
            if (exp_we) check("bus_wdata", dbus_wdata_o, exp_wdata);
            if (gd_cnt == 0) begin
                dbus_gnt_i = 1'b1;
                if (!dbus_we_o) begin
                    pend      = 1'b1;
                    rv_cnt    = rv_delay;
                    pend_data = mem_word(dbus_addr_o);
                end
            end else begin
                gd_cnt--;
            end
        end
    end

    // Monitor: every unstalled cycle retires exactly one instruction.
    always @(negedge clk) begin
        if (sb_en && !rst && !mem_stall_o) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: got retire expected none at %0t", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rd_wdata", mem_rd_wdata_o, e.wdata);
                check("rd_en", {31'b0, mem_rd_en_o}, {31'b0, e.rd_en});
                check("misalign", {31'b0, mem_misalign_o}, {31'b0, e.mis});
                check("rd_idx", {27'b0, mem_rd_idx_o}, {27'b0, e.idx});
                check("pc", mem_pc_o, e.pc);
                check("instr", mem_instr_o, e.instr);
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] wd, input logic en,
                         input logic [4:0] idx, input int d, input int r);
        exp_t        e;
        bit          ld, st, mis, bus, done;
        int          nb, base, stalls, exp_stalls;
        logic [31:0] v;
        ld   = (op == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        st   = (op == 7'b0100011) && (f3 inside {3'd0, 3'd1, 3'd2});
        nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis  = (ld || st) && (addr % nb != 0);
        bus  = (ld || st) && !mis;
        base = int'(addr & 32'h3F);
        e.wdata = wd;
        if (bus && ld) begin
            v = '0;
            for (int b = 0; b < nb; b++) v = v | (32'(mem_b[base+b]) << (8*b));
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            e.wdata = v;
        end
        e.rd_en = en && !mis;
        e.mis   = mis;
        e.idx   = idx;
        e.pc    = $urandom;
        e.instr = {17'b0, f3, idx, op};
        exp_addr = addr & ~32'd3;
        exp_be   = 4'(((1 << nb) - 1) << (addr % 4));
        exp_we   = st;
        for (int k = 0; k < 4; k++) exp_wdata[8*k +: 8] = rs2[8*(k % nb) +: 8];
        if (bus && st)
            for (int b = 0; b < nb; b++) mem_b[base+b] = rs2[8*b +: 8];
        exp_stalls = !bus ? 0 : ld ? 2 + d + r : 1 + d;
        exp_bus  = bus;
        gd_cnt   = d;
        rv_delay = r;
        sbq.push_back(e);
        ex_mem_pc_i        = e.pc;
        ex_mem_instr_i     = e.instr;
        ex_mem_alu_res_i   = addr;
        ex_mem_rs2_rdata_i = rs2;
        ex_mem_rd_wdata_i  = wd;
        ex_mem_rd_en_i     = en;
        ex_mem_rd_idx_i    = idx;
        done   = 1'b0;
        stalls = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!mem_stall_o) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) check("retire_timeout", 32'(stalls), 32'(exp_stalls));
        else       check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input int b, input logic [31:0] w);
        for (int k = 0; k < 4; k++) mem_b[b+k] = w[8*k +: 8];
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
        ex_mem_instr_i   = {17'b0, 3'b010, 5'd3, 7'b0000011};
        ex_mem_alu_res_i = 32'h100;
        ex_mem_rd_en_i   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_req", {31'b0, dbus_req_o}, 32'd0);
            check("rst_stall", {31'b0, mem_stall_o}, 32'd0);
            check("rst_rd_en", {31'b0, mem_rd_en_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        sb_en = 1'b1;

        put_word(0, 32'hDEADBEEF);
        issue(7'b0000011, 3'b010, 32'h100, 32'h0, 32'h1111, 1'b1, 5'd1, 0, 0);
        put_word(0, 32'h80FFFFFF);
        issue(7'b0000011, 3'b000, 32'h103, 32'h0, 32'h2222, 1'b1, 5'd2, 0, 0);
        issue(7'b0000011, 3'b100, 32'h103, 32'h0, 32'h3333, 1'b1, 5'd3, 1, 2);
        put_word(0, 32'h8001ABCD);
        issue(7'b0000011, 3'b101, 32'h102, 32'h0, 32'h4444, 1'b1, 5'd4, 0, 1);
        issue(7'b0100011, 3'b001, 32'h106, 32'h1234ABCD, 32'h5555, 1'b0, 5'd0, 3, 0);
        issue(7'b0000011, 3'b010, 32'h102, 32'h0, 32'h6666, 1'b1, 5'd5, 0, 0);
        issue(7'b0000011, 3'b010, 32'h104, 32'h0, 32'h7777, 1'b1, 5'd6, 0, 0);
        issue(7'b0110011, 3'b000, 32'h104, 32'h0, 32'h8888, 1'b1, 5'd7, 0, 0);
        issue(7'b0000011, 3'b001, 32'h106, 32'h0, 32'h9999, 1'b1, 5'd8, 2, 1);
        issue(7'b0000011, 3'b010, 32'h108, 32'h0, 32'hAAAA, 1'b0, 5'd0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int          k;
            logic [6:0]  op;
            logic [2:0]  f3;
            k = $urandom_range(0, 9);
            op = 7'b0000011;
            f3 = 3'b011;
            case (k)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                4: f3 = 3'b101;
                5, 6, 7: begin op = 7'b0100011; f3 = 3'(k - 5); end
                8: begin op = 7'b0110011; f3 = 3'($urandom); end
                default: ;
            endcase
            issue(op, f3, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while waiting for read data, then a stale rvalid arrives.
        sb_en    = 1'b0;
        exp_addr = 32'h108; exp_be = 4'hF; exp_we = 1'b0; exp_bus = 1'b1;
        gd_cnt   = 0; rv_delay = 6;
        ex_mem_instr_i   = {17'b0, 3'b010, 5'd9, 7'b0000011};
        ex_mem_alu_res_i = 32'h108;
        ex_mem_rd_en_i   = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wait_stall", {31'b0, mem_stall_o}, 32'd1);
        check("wait_req", {31'b0, dbus_req_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", {31'b0, dbus_req_o}, 32'd0);
        check("midrst_stall", {31'b0, mem_stall_o}, 32'd0);
        check("midrst_rd_en", {31'b0, mem_rd_en_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_bus = 1'b0;
        ex_mem_instr_i    = {17'b0, 3'b000, 5'd10, 7'b0110011};
        ex_mem_rd_wdata_i = 32'h55;
        repeat (8) begin
            @(negedge clk);
            check("postrst_stall", {31'b0, mem_stall_o}, 32'd0);
            check("postrst_wdata", mem_rd_wdata_o, 32'h55);
            check("postrst_rd_en", {31'b0, mem_rd_en_o}, 32'd1);
        end
        check("rvalid_fired", {31'b0, pend}, 32'd0);
        @(posedge clk);
        #1;
        sb_en = 1'b1;
        put_word(8, 32'hCAFEF00D);
        issue(7'b0000011, 3'b010, 32'h108, 32'h0, 32'hBBBB, 1'b1, 5'd11, 0, 0);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
